// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation encodings and a helper classifying them.
// Imported by the datapath, the bench and the CPU decoder.
package alu_pkg;

    typedef enum logic [2:0] {
        OP_PASS_B  = 3'b000,
        OP_UNUSED1 = 3'b001,
        OP_ADD     = 3'b010,
        OP_SUB     = 3'b011,
        OP_AND     = 3'b100,
        OP_OR      = 3'b101,
        OP_XOR     = 3'b110,
        OP_UNUSED7 = 3'b111
    } alu_op_e;

    localparam int DEFAULT_WIDTH = 64;

    // Only add and subtract drive the overflow and carry flags.
    function automatic logic is_arith(alu_op_e op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/alu_bitslice.sv
// One bit of the ALU datapath: full adder with optional B inversion,
// bitwise logic ops and the per-bit result select.
module alu_bitslice
    import alu_pkg::*;
(
    input  logic    a,
    input  logic    b,
    input  logic    b_invert,
    input  logic    carry_in,
    input  alu_op_e op,
    output logic    result,
    output logic    carry_out
);

    logic b_eff;
    logic sum;

    assign b_eff     = b ^ b_invert;
    assign sum       = a ^ b_eff ^ carry_in;
    assign carry_out = (a & b_eff) | (carry_in & (a ^ b_eff));

    always_comb begin
        result = 1'b0;
        unique case (op)
            OP_PASS_B:      result = b;
            OP_ADD, OP_SUB: result = sum;
            OP_AND:         result = a & b;
            OP_OR:          result = a | b;
            OP_XOR:         result = a ^ b;
            default:        result = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu.sv
// Ripple-carry ALU built from WIDTH bit slices, with registered result
// and status flags; one-cycle latency, a new operation every cycle.
module alu
    import alu_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       cntrl,
    output logic [WIDTH-1:0] result,
    output logic             negative,
    output logic             zero,
    output logic             overflow,
    output logic             carry_out
);

    alu_op_e          op;
    logic             sub;
    logic             arith;
    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] slice_result;
    logic             b_msb_eff;
    logic             overflow_next;
    logic             carry_next;

    assign op       = alu_op_e'(cntrl);
    assign sub      = (op == OP_SUB);
    assign arith    = is_arith(op);
    // Subtract is A + ~B + 1: invert B in every slice and seed the chain with 1.
    assign carry[0] = sub;

    for (genvar i = 0; i < WIDTH; i++) begin : g_slice
        alu_bitslice u_slice (
            .a         (A[i]),
            .b         (B[i]),
            .b_invert  (sub),
            .carry_in  (carry[i]),
            .op        (op),
            .result    (slice_result[i]),
            .carry_out (carry[i+1])
        );
    end

    assign b_msb_eff     = B[WIDTH-1] ^ sub;
    assign overflow_next = arith && (A[WIDTH-1] == b_msb_eff)
                                 && (slice_result[WIDTH-1] != A[WIDTH-1]);
    assign carry_next    = arith && carry[WIDTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            result    <= '0;
            negative  <= 1'b0;
            zero      <= 1'b1;
            overflow  <= 1'b0;
            carry_out <= 1'b0;
        end else begin
            result    <= slice_result;
            negative  <= slice_result[WIDTH-1];
            zero      <= ~|slice_result;
            overflow  <= overflow_next;
            carry_out <= carry_next;
        end
    end

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: an arithmetic reference model checked every
// cycle, plus literal boundary vectors that pin the model.
module tb_alu;
    import alu_pkg::*;

    localparam logic [63:0] ALL_ONES = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] MIN_NEG  = 64'h8000_0000_0000_0000;
    localparam logic [63:0] MAX_POS  = 64'h7FFF_FFFF_FFFF_FFFF;
    localparam logic signed [65:0] SMAX = 66'sh0_7FFF_FFFF_FFFF_FFFF;
    localparam logic signed [65:0] SMIN = -66'sh0_8000_0000_0000_0000;

    typedef struct packed {
        logic [63:0] result;
        logic        negative;
        logic        zero;
        logic        overflow;
        logic        carry_out;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] a;
    logic [63:0] b;
    logic [2:0]  cntrl;
    logic [63:0] result;
    logic        negative;
    logic        zero;
    logic        overflow;
    logic        carry_out;

    int   tests_run    = 0;
    int   tests_failed = 0;
    exp_t exp_q;
    logic exp_valid = 1'b0;
    int   cycle     = 0;

    alu #(.WIDTH(64)) dut (
        .clk       (clk),
        .reset     (reset),
        .A         (a),
        .B         (b),
        .cntrl     (cntrl),
        .result    (result),
        .negative  (negative),
        .zero      (zero),
        .overflow  (overflow),
        .carry_out (carry_out)
    );

    always #5 clk = ~clk;

    // Reference: signed overflow as an out-of-range check on exact integers.
    function automatic exp_t ref_model(logic [63:0] opa, logic [63:0] opb,
                                       logic [2:0] op, logic rst);
        exp_t e;
        logic [64:0]        usum;
        logic signed [65:0] ssum;
        e = '0;
        if (!rst) begin
            case (op)
                OP_PASS_B: e.result = opb;
                OP_ADD: begin
                    usum        = {1'b0, opa} + {1'b0, opb};
                    ssum        = $signed({{2{opa[63]}}, opa}) + $signed({{2{opb[63]}}, opb});
                    e.result    = usum[63:0];
                    e.carry_out = usum[64];
                    e.overflow  = (ssum > SMAX) || (ssum < SMIN);
                end
                OP_SUB: begin
                    ssum        = $signed({{2{opa[63]}}, opa}) - $signed({{2{opb[63]}}, opb});
                    e.result    = opa - opb;
                    e.carry_out = (opa >= opb);
                    e.overflow  = (ssum > SMAX) || (ssum < SMIN);
                end
                OP_AND: e.result = opa & opb;
                OP_OR:  e.result = opa | opb;
                OP_XOR: e.result = opa ^ opb;
                default: e.result = '0;
            endcase
        end
        e.negative = e.result[63];
        e.zero     = (e.result == '0);
        return e;
    endfunction

    function automatic logic [63:0] rand_operand();
        logic [31:0] hi;
        logic [31:0] lo;
        hi = $urandom;
        lo = $urandom;
        case ($urandom_range(0, 9))
            0:       return ALL_ONES;
            1:       return MIN_NEG;
            2:       return MAX_POS;
            3:       return 64'd0;
            4:       return 64'd1;
            default: return {hi, lo};
        endcase
    endfunction

    always @(posedge clk) begin
        exp_q     <= ref_model(a, b, cntrl, reset);
        exp_valid <= 1'b1;
        cycle     <= cycle + 1;
    end

    // Every cycle, the registered outputs must match the model's prediction.
    always @(negedge clk) begin
        if (exp_valid) begin
            tests_run++;
            if ({result, negative, zero, overflow, carry_out} !== exp_q) begin
                tests_failed++;
                $display("[TB] FAIL model cycle %0d: got result=%h n=%b z=%b v=%b c=%b, expected result=%h n=%b z=%b v=%b c=%b",
                         cycle, result, negative, zero, overflow, carry_out,
                         exp_q.result, exp_q.negative, exp_q.zero, exp_q.overflow, exp_q.carry_out);
            end
        end
    end

    task automatic apply_stimulus(logic [63:0] opa, logic [63:0] opb,
                                  logic [2:0] op, logic rst);
        @(negedge clk);
        a     = opa;
        b     = opb;
        cntrl = op;
        reset = rst;
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(string name, logic [63:0] r, logic n,
                                logic z, logic v, logic c);
        tests_run++;
        if ({result, negative, zero, overflow, carry_out} !== {r, n, z, v, c}) begin
            tests_failed++;
            $display("[TB] FAIL %s: got result=%h n=%b z=%b v=%b c=%b, expected result=%h n=%b z=%b v=%b c=%b",
                     name, result, negative, zero, overflow, carry_out, r, n, z, v, c);
        end
    endtask

    initial begin
        reset = 1'b1;
        a     = ALL_ONES;
        b     = ALL_ONES;
        cntrl = OP_ADD;

        repeat (2) apply_stimulus(rand_operand(), rand_operand(), OP_ADD, 1'b1);
        check_output("reset_state", 64'd0, 1'b0, 1'b1, 1'b0, 1'b0);

        apply_stimulus(MAX_POS, 64'd1, OP_ADD, 1'b0);
        check_output("add_max_plus_one", MIN_NEG, 1'b1, 1'b0, 1'b1, 1'b0);
        apply_stimulus(MIN_NEG, MIN_NEG, OP_ADD, 1'b0);
        check_output("add_min_plus_min", 64'd0, 1'b0, 1'b1, 1'b1, 1'b1);
        apply_stimulus(64'd1, ALL_ONES, OP_ADD, 1'b0);
        check_output("add_one_plus_ones", 64'd0, 1'b0, 1'b1, 1'b0, 1'b1);
        apply_stimulus(64'd0, ALL_ONES, OP_SUB, 1'b0);
        check_output("sub_zero_minus_ones", 64'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        apply_stimulus(MAX_POS, MAX_POS, OP_SUB, 1'b0);
        check_output("sub_max_minus_max", 64'd0, 1'b0, 1'b1, 1'b0, 1'b1);
        apply_stimulus(64'h8000_0000_0000_0001, 64'h8FFF_FFFF_FFFF_FFF1, OP_AND, 1'b0);
        check_output("and_pattern", 64'h8000_0000_0000_0001, 1'b1, 1'b0, 1'b0, 1'b0);
        apply_stimulus(64'h8000_0000_0000_0001, 64'h8FFF_FFFF_FFFF_FFF1, OP_OR, 1'b0);
        check_output("or_pattern", 64'h8FFF_FFFF_FFFF_FFF1, 1'b1, 1'b0, 1'b0, 1'b0);
        apply_stimulus(64'h8000_0000_0000_0001, 64'h8FFF_FFFF_FFFF_FFF1, OP_XOR, 1'b0);
        check_output("xor_pattern", 64'h0FFF_FFFF_FFFF_FFF0, 1'b0, 1'b0, 1'b0, 1'b0);
        apply_stimulus(ALL_ONES, 64'd0, OP_PASS_B, 1'b0);
        check_output("pass_b_zero", 64'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        apply_stimulus(ALL_ONES, ALL_ONES, OP_UNUSED1, 1'b0);
        check_output("unused_code_1", 64'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        apply_stimulus(ALL_ONES, ALL_ONES, OP_UNUSED7, 1'b0);
        check_output("unused_code_7", 64'd0, 1'b0, 1'b1, 1'b0, 1'b0);

        // Reset arriving in the middle of back-to-back adds.
        apply_stimulus(64'd3, 64'd4, OP_ADD, 1'b0);
        check_output("b2b_add_first", 64'd7, 1'b0, 1'b0, 1'b0, 1'b0);
        apply_stimulus(MAX_POS, MAX_POS, OP_ADD, 1'b1);
        check_output("mid_stream_reset", 64'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        apply_stimulus(64'd5, 64'd7, OP_ADD, 1'b0);
        check_output("first_after_reset", 64'd12, 1'b0, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 100; i++) begin
            apply_stimulus(rand_operand(), rand_operand(), OP_PASS_B, 1'b0);
        end
        for (int i = 0; i < 400; i++) begin
            apply_stimulus(rand_operand(), rand_operand(),
                           ($urandom_range(0, 1) == 0) ? OP_ADD : OP_SUB, 1'b0);
        end
        for (int i = 0; i < 300; i++) begin
            apply_stimulus(rand_operand(), rand_operand(), 3'($urandom_range(0, 7)),
                           ($urandom_range(0, 15) == 0));
        end

        repeat (2) @(posedge clk);
        #2;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/alu.md
ALU -- requirements
Module: alu

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Parameter: WIDTH, default 64, datapath width in bits; all arithmetic and flag rules below SHALL be stated for WIDTH=64.
REQ-003 Port: clk  input  1  rising-edge clock for all state.
REQ-004 Port: reset  input  1  synchronous active-high reset.
REQ-005 Port: A  input  WIDTH  operand A.
REQ-006 Port: B  input  WIDTH  operand B.
REQ-007 Port: cntrl  input  3  operation select.
REQ-008 Port: result  output  WIDTH  registered operation result.
REQ-009 Port: negative  output  1  registered copy of result[WIDTH-1].
REQ-010 Port: zero  output  1  registered flag, 1 when result is all-zero.
REQ-011 Port: overflow  output  1  registered signed-overflow flag for add/subtract.
REQ-012 Port: carry_out  output  1  registered carry out of the MSB for add/subtract.

Function
REQ-013 Operation encoding SHALL be: 000 result=B; 010 A+B; 011 A-B; 100 A&B; 101 A|B; 110 A^B.
REQ-014 Codes 001 and 111 SHALL produce result=0, zero=1, negative=0, overflow=0, carry_out=0.
REQ-015 Operands and cntrl sampled at rising edge N SHALL appear on all outputs after edge N (latency one cycle, new result every cycle, no handshake).
REQ-016 Add SHALL compute A+B modulo 2^WIDTH; carry_out = bit WIDTH of the unsigned sum.
REQ-017 Subtract SHALL compute A+~B+1; carry_out = carry of that sum (1 = no borrow; A>=B unsigned gives carry_out=1).
REQ-018 overflow SHALL be 1 for add/subtract iff both adder inputs (A and B, or A and ~B) have equal sign and the result sign differs.
REQ-019 For pass-B, AND, OR, XOR, and unused codes, overflow and carry_out SHALL be 0.
REQ-020 negative and zero SHALL be derived from the result for every operation, including pass-B and logic ops.
REQ-021 Full-width boundaries (all-ones, 0x8000_0000_0000_0000, 0x7FFF_FFFF_FFFF_FFFF) SHALL wrap modulo 2^WIDTH with flags per REQ-016..018.

Reset
REQ-022 While reset is high at a rising edge, result SHALL become 0, zero 1, negative 0, overflow 0, carry_out 0.
REQ-023 Reset SHALL take priority over any input; the first valid result SHALL appear at the first rising edge with reset low.
REQ-024 Reset asserted mid-stream SHALL discard the in-flight result; no other state exists.

Structure
REQ-025 The cntrl encodings SHALL be named constants in a shared package alu_pkg, also used by the bench and CPU decoder.
REQ-026 The datapath SHALL be built from a per-bit sub-module alu_bitslice (full adder with B-invert, AND/OR/XOR, result mux), replicated WIDTH times with ripple carry; flag logic and output registers sit in alu.
REQ-027 Subtraction SHALL reuse the adder via B inversion and carry-in 1; no separate subtractor.

Verification
REQ-028 ADD A=0x7FFF_FFFF_FFFF_FFFF, B=1 -> result 0x8000_0000_0000_0000, negative 1, overflow 1, carry_out 0, zero 0, one cycle later.
REQ-029 ADD A=0x8000_0000_0000_0000, B=0x8000_0000_0000_0000 -> result 0, zero 1, carry_out 1, overflow 1; ADD A=1, B=all-ones -> result 0, zero 1, carry_out 1, overflow 0.
REQ-030 SUB A=0, B=all-ones -> result 1, carry_out 0, overflow 0; SUB A=B=0x7FFF_FFFF_FFFF_FFFF -> result 0, zero 1, carry_out 1.
REQ-031 AND/OR/XOR A=0x8000_0000_0000_0001, B=0x8FFF_FFFF_FFFF_FFF1 -> 0x8000_0000_0000_0001 (neg 1), 0x8FFF_FFFF_FFFF_FFF1 (neg 1), 0x0FFF_FFFF_FFFF_FFF0 (neg 0); overflow and carry_out 0.
REQ-032 PASS_B with 100 random A/B -> result==B, negative==B[63], zero==(B==0) every cycle; a reference model checks all flags for random ADD/SUB vectors.
REQ-033 Assert reset during back-to-back ADDs -> next edge gives result 0, zero 1, other flags 0; first post-reset operation appears one cycle after reset deasserts.
